// File: rtl/child_status_collector.sv
// child_status_collector
// Fan-in of NUM_CHILD child status streams into one valid/ready stream toward the root.
// A round-robin arbiter grants one child per cycle into a single-entry output register,
// so no child can starve.
//
// Ports:
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   child_valid   per-child request
//   child_data    packed child words, child i at [i*DATA_W +: DATA_W]
//   child_ready   one-hot accept strobe to the granted child (combinational)
//   m_valid       output register holds a word
//   m_data        held word
//   m_src         index of the child that produced m_data
//   m_ready       downstream accept
//   xfer_cnt      16-bit downstream transfer count (only with XFER_CNT_EN defined)
//
// Configuration macro: XFER_CNT_EN adds the xfer_cnt port and counter.

module child_status_collector #(
  parameter int unsigned NUM_CHILD = 5,
  parameter int unsigned DATA_W    = 8,
  // Derived; do not override.
  parameter int unsigned SRC_W     = $clog2(NUM_CHILD)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CHILD-1:0]        child_valid,
  input  logic [NUM_CHILD*DATA_W-1:0] child_data,
  output logic [NUM_CHILD-1:0]        child_ready,
  output logic                        m_valid,
  output logic [DATA_W-1:0]           m_data,
  output logic [SRC_W-1:0]            m_src,
  input  logic                        m_ready
`ifdef XFER_CNT_EN
  ,
  output logic [15:0]                 xfer_cnt
`endif
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] data_q;
  logic [SRC_W-1:0]  src_q;
  logic [SRC_W-1:0]  ptr_q;

  logic [DATA_W-1:0] data_arr [NUM_CHILD];
  logic [SRC_W-1:0]  grant;
  logic [SRC_W-1:0]  idx_s;
  logic [SRC_W-1:0]  ptr_nxt;
  logic              found;
  logic              can_load;
  logic              accept;
  int unsigned       idx;

  for (genvar i = 0; i < NUM_CHILD; i++) begin : g_unpack
    assign data_arr[i] = child_data[i*DATA_W +: DATA_W];
  end

  // Scan ptr, ptr+1, ... with wrap; first requesting child wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    idx_s = '0;
    for (int unsigned k = 0; k < NUM_CHILD; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NUM_CHILD) idx = idx - NUM_CHILD;
      idx_s = SRC_W'(idx);
      if (!found && child_valid[idx_s]) begin
        found = 1'b1;
        grant = idx_s;
      end
    end
  end

  assign m_valid  = (state_q == StFull);
  assign can_load = !m_valid || m_ready;
  // rst_n gating keeps child_ready low for the whole reset assertion, not just after an edge.
  assign accept   = rst_n && can_load && found;
  assign ptr_nxt  = (grant == SRC_W'(NUM_CHILD - 1)) ? '0 : grant + SRC_W'(1);

  always_comb begin
    child_ready = '0;
    if (accept) child_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      data_q  <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) state_q <= StFull;
        end
        StFull: begin
          if (!accept && m_ready) state_q <= StEmpty;
        end
        default: state_q <= StEmpty;
      endcase
      if (accept) begin
        data_q <= data_arr[grant];
        src_q  <= grant;
        ptr_q  <= ptr_nxt;
      end
    end
  end

  assign m_data = data_q;
  assign m_src  = src_q;

`ifdef XFER_CNT_EN
  logic [15:0] xfer_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_q <= '0;
    end else if (m_valid && m_ready) begin
      xfer_cnt_q <= xfer_cnt_q + 16'd1;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
`endif

endmodule
